// File: rtl/cram_loader.sv
// cram_loader: write-side front end for the 256x16 palette CRAM.
// Z80 byte writes are paired into 16-bit words (low byte latched, high byte
// commits), DMA supplies whole words. Both feed one small in-order FIFO that
// drains to the CRAM write port, optionally only while the raster is blanked.
module cram_loader #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [8:0]  cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        dma_valid,
    input  logic [7:0]  dma_addr,
    input  logic [15:0] dma_data,
    output logic        dma_ready,
    input  logic        defer_en,
    input  logic        blank,
    output logic [7:0]  cram_addr,
    output logic [15:0] cram_data,
    output logic        cram_we,
    output logic        busy,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    lo;

    logic   cpu_commit, full, cpu_push, dma_push, push, pop;
    entry_t push_ent;

    // Push/pop decisions. Fullness is judged on the registered count only, so
    // a pop in the same cycle never makes room for a push.
    always_comb begin
        cpu_commit = cpu_wr & cpu_addr[0];
        full       = (count == FULL_CNT);
        dma_ready  = ~full & ~cpu_commit;
        cpu_push   = cpu_commit & ~full;
        dma_push   = dma_valid & dma_ready;
        push       = cpu_push | dma_push;
        pop        = (count != '0) & (~defer_en | blank);
        push_ent   = cpu_commit ? entry_t'({cpu_addr[8:1], cpu_data, lo})
                                : entry_t'({dma_addr, dma_data});
        count_nxt  = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Low-byte latch; high-byte writes reuse it without disturbing it.
    always_ff @(posedge clk) begin
        if (rst)
            lo <= '0;
        else if (cpu_wr && !cpu_addr[0])
            lo <= cpu_data;
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= 1'b0;
        else if (cpu_commit && full)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_ent;
    end

    // FIFO pointers, occupancy and the registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
            busy  <= (count_nxt != '0);
        end
    end

    // CRAM write port: one registered pulse per popped entry, address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cram_we   <= 1'b0;
            cram_addr <= '0;
            cram_data <= '0;
        end else begin
            cram_we <= pop;
            if (pop) begin
                cram_addr <= mem[rd_ptr].addr;
                cram_data <= mem[rd_ptr].data;
            end
        end
    end

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader: byte pairing, DMA streaming under deferral,
// CPU/DMA arbitration, overflow, mid-operation reset and low-byte reuse.
module tb_cram_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr;
    logic [8:0]  cpu_addr;
    logic [7:0]  cpu_data;
    logic        dma_valid;
    logic [7:0]  dma_addr;
    logic [15:0] dma_data;
    logic        dma_ready;
    logic        defer_en;
    logic        blank;
    logic [7:0]  cram_addr;
    logic [15:0] cram_data;
    logic        cram_we;
    logic        busy;
    logic        ovf;
    logic        ovf_clr;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0]  log_a[$];
    logic [15:0] log_d[$];
    int          log_c[$];

    cram_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_data(dma_data),
        .dma_ready(dma_ready),
        .defer_en(defer_en), .blank(blank),
        .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every CRAM write away from the active edge.
    always @(negedge clk) begin
        if (cram_we) begin
            log_a.push_back(cram_addr);
            log_d.push_back(cram_data);
            log_c.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic cpu_byte(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic drain();
        int c;
        for (c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy && !cram_we) break;
        end
        chk("drain_timeout", 32'(c < 60), 1);
    endtask

    initial begin
        int i;
        int n10;
        rst = 1'b1; cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
        dma_valid = 1'b0; dma_addr = '0; dma_data = '0;
        defer_en = 1'b0; blank = 1'b0; ovf_clr = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", cram_we, 0);
        chk("rst_addr", cram_addr, 0);
        chk("rst_data", cram_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dma_ready", dma_ready, 1);
        rst = 1'b0;

        // T1: byte pairing and latency
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 9'h00A; cpu_data = 8'h34;
        @(negedge clk);
        chk("t1_lo_no_push", busy, 0);
        cpu_addr = 9'h00B; cpu_data = 8'h92;
        @(negedge clk);
        cpu_wr = 1'b0;
        chk("t1_we_push_cycle", cram_we, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_we", cram_we, 1);
        chk("t1_addr", cram_addr, 8'h05);
        chk("t1_data", cram_data, 16'h9234);
        @(negedge clk);
        chk("t1_we_single", cram_we, 0);
        chk("t1_data_hold", cram_data, 16'h9234);
        chk("t1_nwrites", log_a.size(), 1);
        clr_log();

        // T2: DMA streaming, deferred until blank
        defer_en = 1'b1; blank = 1'b0; i = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dma_valid = 1'b1; dma_addr = i[7:0]; dma_data = 16'h1000 + i[15:0];
            #1;
            if (dma_ready) i++;
        end
        @(negedge clk);
        dma_addr = i[7:0]; dma_data = 16'h1000 + i[15:0];
        #1;
        chk("t2_full_ready", dma_ready, 0);
        chk("t2_accepted", i, 4);
        chk("t2_deferred", log_a.size(), 0);
        blank = 1'b1;
        for (int c = 0; c < 40 && i < 8; c++) begin
            @(negedge clk);
            dma_addr = i[7:0]; dma_data = 16'h1000 + i[15:0];
            #1;
            if (dma_ready) i++;
        end
        @(negedge clk);
        dma_valid = 1'b0;
        drain();
        chk("t2_total_accepted", i, 8);
        chk("t2_nwrites", log_a.size(), 8);
        for (int k = 0; k < 8 && k < log_a.size(); k++) begin
            chk($sformatf("t2_addr%0d", k), log_a[k], k);
            chk($sformatf("t2_data%0d", k), log_d[k], 32'h1000 + k);
        end
        for (int k = 0; k < 3 && k + 1 < log_c.size(); k++)
            chk($sformatf("t2_b2b%0d", k), log_c[k+1] - log_c[k], 1);
        clr_log();
        blank = 1'b0; defer_en = 1'b0;

        // T3: CPU commit beats DMA in the same cycle
        cpu_byte(9'h000, 8'hAA);
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = {8'h20, 1'b1}; cpu_data = 8'hBB;
        dma_valid = 1'b1; dma_addr = 8'h21; dma_data = 16'h4321;
        #1;
        chk("t3_ready_blocked", dma_ready, 0);
        @(negedge clk);
        cpu_wr = 1'b0;
        #1;
        chk("t3_ready_next", dma_ready, 1);
        @(negedge clk);
        dma_valid = 1'b0;
        drain();
        chk("t3_nwrites", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("t3_first_addr", log_a[0], 8'h20);
            chk("t3_first_data", log_d[0], 16'hBBAA);
            chk("t3_second_addr", log_a[1], 8'h21);
            chk("t3_second_data", log_d[1], 16'h4321);
        end
        clr_log();

        // T4: overflow drop, sticky flag, set-wins-over-clear
        defer_en = 1'b1; blank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dma_valid = 1'b1; dma_addr = 8'h30 + k[7:0]; dma_data = 16'h2000 + k[15:0];
        end
        @(negedge clk);
        dma_valid = 1'b0;
        #1;
        chk("t4_full_ready", dma_ready, 0);
        chk("t4_ovf_pre", ovf, 0);
        cpu_wr = 1'b1; cpu_addr = {8'h10, 1'b1}; cpu_data = 8'hCC;
        @(negedge clk);
        cpu_wr = 1'b0;
        chk("t4_ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 0);
        cpu_wr = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        cpu_wr = 1'b0; ovf_clr = 1'b0;
        chk("t4_set_wins", ovf, 1);
        @(negedge clk);
        chk("t4_sticky", ovf, 1);
        blank = 1'b1;
        drain();
        chk("t4_nwrites", log_a.size(), 4);
        n10 = 0;
        foreach (log_a[k]) if (log_a[k] == 8'h10) n10++;
        chk("t4_dropped_absent", n10, 0);
        if (log_a.size() == 4) begin
            chk("t4_addr_first", log_a[0], 8'h30);
            chk("t4_addr_last", log_a[3], 8'h33);
        end
        chk("t4_sticky_after_drain", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t4_ovf_final_clr", ovf, 0);
        clr_log();

        // T5: reset discards queued entries and the low-byte latch
        defer_en = 1'b1; blank = 1'b0;
        cpu_byte(9'h000, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dma_valid = 1'b1; dma_addr = 8'h40 + k[7:0]; dma_data = 16'h3000 + k[15:0];
        end
        @(negedge clk);
        dma_valid = 1'b0;
        chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy_rst", busy, 0);
        chk("t5_we_rst", cram_we, 0);
        blank = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_no_writes", log_a.size(), 0);
        chk("t5_busy_post", busy, 0);
        defer_en = 1'b0; blank = 1'b0;
        cpu_byte({8'h07, 1'b1}, 8'h77);
        drain();
        chk("t5_lo_nwrites", log_a.size(), 1);
        if (log_a.size() == 1) begin
            chk("t5_lo_addr", log_a[0], 8'h07);
            chk("t5_lo_data", log_d[0], 16'h7700);
        end
        clr_log();

        // T6: low byte reused by consecutive high-byte commits
        cpu_byte(9'h000, 8'h55);
        cpu_byte({8'h03, 1'b1}, 8'h01);
        cpu_byte({8'h04, 1'b1}, 8'h02);
        drain();
        chk("t6_nwrites", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("t6_addr0", log_a[0], 8'h03);
            chk("t6_data0", log_d[0], 16'h0155);
            chk("t6_addr1", log_a[1], 8'h04);
            chk("t6_data1", log_d[1], 16'h0255);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
